// File: rtl/countdown_timer_if.sv
// -----------------------------------------------------------------------------
// countdown_timer_if
// Command/status bundle of the loadable countdown timer.
//   load        : load load_value into the counter (highest priority command)
//   load_value  : seconds to count down from (0..1023)
//   start       : begin or resume counting
//   pause       : suspend counting, prescaler holds
//   out         : remaining seconds (registered)
//   running     : high while counting
//   done        : one-cycle pulse when out reaches 0 by counting
//   expired     : high while the timer sits at expiry
// master drives commands and observes status; slave is the timer itself.
// -----------------------------------------------------------------------------
interface countdown_timer_if;
    logic       load;
    logic [9:0] load_value;
    logic       start;
    logic       pause;
    logic [9:0] out;
    logic       running;
    logic       done;
    logic       expired;

    modport master (
        output load, load_value, start, pause,
        input  out, running, done, expired
    );

    modport slave (
        input  load, load_value, start, pause,
        output out, running, done, expired
    );
endinterface

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
// Loadable down-counting seconds timer. A prescaler divides clk by `second`
// to produce one tick per second while running; each tick decrements out.
// Reaching zero by counting pulses done for one cycle and parks the block
// in EXPIRED until a new load or reset.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : countdown_timer_if.slave (load/load_value/start/pause in,
//           out/running/done/expired out, all outputs registered)
// Parameter:
//   second : clock cycles per one-second tick (>= 2)
// -----------------------------------------------------------------------------
module countdown_timer #(
    parameter int unsigned second = 32'd50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    countdown_timer_if.slave  bus
);

    localparam int unsigned          PRESC_W   = $clog2(second);
    localparam logic [PRESC_W-1:0]   PRESC_MAX = PRESC_W'(second - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [9:0]           out_r;
    logic [9:0]           out_next_s;
    logic [PRESC_W-1:0]   presc_r;
    logic [PRESC_W-1:0]   presc_next_s;
    logic                 done_r;
    logic                 done_next_s;
    logic                 running_r;
    logic                 expired_r;

    // Next-state, next-count and done-pulse decode; load overrides every state.
    always_comb begin
        state_next_s = state_r;
        out_next_s   = out_r;
        presc_next_s = presc_r;
        done_next_s  = 1'b0;

        if (bus.load) begin
            out_next_s   = bus.load_value;
            presc_next_s = '0;
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Starting from zero would expire without counting; ignore it.
                    if (bus.start && (out_r != 10'd0)) begin
                        state_next_s = ST_RUN;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (bus.pause) begin
                        // Pause beats a coincident tick: prescaler keeps its value.
                        state_next_s = ST_PAUSED;
                    end else if (presc_r == PRESC_MAX) begin
                        presc_next_s = '0;
                        if (out_r > 10'd1) begin
                            out_next_s = out_r - 10'd1;
                        end else begin
                            // Last second consumed: zero is terminal, never wraps.
                            out_next_s   = 10'd0;
                            state_next_s = ST_EXPIRED;
                            done_next_s  = (out_r == 10'd1);
                        end
                    end else begin
                        presc_next_s = presc_r + PRESC_W'(1);
                    end
                end
                ST_PAUSED: begin
                    // start wins over a simultaneous pause.
                    if (bus.start) begin
                        state_next_s = ST_RUN;
                    end else begin
                        state_next_s = ST_PAUSED;
                    end
                end
                ST_EXPIRED: begin
                    out_next_s   = 10'd0;
                    state_next_s = ST_EXPIRED;
                end
                default: begin
                    out_next_s   = 10'd0;
                    presc_next_s = '0;
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, counter, prescaler and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            out_r     <= 10'd0;
            presc_r   <= '0;
            done_r    <= 1'b0;
            running_r <= 1'b0;
            expired_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            out_r     <= out_next_s;
            presc_r   <= presc_next_s;
            done_r    <= done_next_s;
            running_r <= (state_next_s == ST_RUN);
            expired_r <= (state_next_s == ST_EXPIRED);
        end
    end

    assign bus.out     = out_r;
    assign bus.running = running_r;
    assign bus.done    = done_r;
    assign bus.expired = expired_r;

endmodule
